// File: rtl/uart_host_rx.sv
// UART receiver (8N1, LSB first) with a first-word-fall-through byte FIFO for the host end of the serial link.
// Optional even-parity checking is enabled by defining UART_HOST_RX_PARITY_EN.
module uart_host_rx #(
    parameter int unsigned SYS_CLK_FREQ = 100000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int unsigned CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE;
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned PW           = AW + 1;
    localparam logic [CW-1:0] HALF_M1    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1    = CW'(CLKS_PER_BIT - 1);

`ifdef UART_HOST_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;
`endif

    state_t        state, state_n;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          push_q, push_n;
    logic          ferr_n;
    logic          par_bad, par_bad_n;

    // Two-flop synchroniser; idles high so reset never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
            par_bad   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bitcnt    <= bitcnt_n;
            shreg     <= shreg_n;
            push_q    <= push_n;
            frame_err <= ferr_n;
            par_bad   <= par_bad_n;
        end
    end

`ifdef UART_HOST_RX_PARITY_EN
    logic perr_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= perr_n;
    end
`else
    assign parity_err = 1'b0;
`endif

    // IDLE only ever holds with rx_s high, so a low rx_s there is the 1->0 start edge
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bitcnt_n  = bitcnt;
        shreg_n   = shreg;
        push_n    = 1'b0;
        ferr_n    = 1'b0;
        par_bad_n = par_bad;
`ifdef UART_HOST_RX_PARITY_EN
        perr_n    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_n     = '0;
                par_bad_n = 1'b0;
                if (!rx_s) state_n = S_START;
            end
            S_START: begin
                if (cnt == HALF_M1) begin
                    cnt_n    = '0;
                    bitcnt_n = '0;
                    state_n  = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n    = '0;
                    shreg_n  = {rx_s, shreg[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
`ifdef UART_HOST_RX_PARITY_EN
                    if (bitcnt == 3'd7) state_n = S_PARITY;
`else
                    if (bitcnt == 3'd7) state_n = S_STOP;
`endif
                end
            end
`ifdef UART_HOST_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == FULL_M1) begin
                    cnt_n     = '0;
                    par_bad_n = ^{shreg, rx_s};
                    perr_n    = par_bad_n;
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        push_n  = !par_bad;
                        state_n = S_IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Receive FIFO; shreg stays stable through the push cycle so it is the write data
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = rd_en && !empty;
        do_push  = push_q && (!full || do_pop);
        wr_ptr_n = do_push ? wr_ptr + PW'(1) : wr_ptr;
        rd_ptr_n = do_pop  ? rd_ptr + PW'(1) : rd_ptr;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    // rd_data is a registered copy of the next head, bypassing a byte written into an empty slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
            rd_data  <= '0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            empty  <= (wr_ptr_n == rd_ptr_n);
            full   <= (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) && (wr_ptr_n[AW] != rd_ptr_n[AW]);
            if (push_q && full && !do_pop) overflow <= 1'b1;
            if (do_push || do_pop) begin
                if (do_push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) rd_data <= shreg;
                else                                                  rd_data <= mem[rd_ptr_n[AW-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_uart_host_rx.sv
// Directed self-checking bench for uart_host_rx at 16 clocks per bit, 16-entry FIFO.
module tb_uart_host_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       frame_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;

`ifdef UART_HOST_RX_PARITY_EN
    logic par_inv = 1'b0;
`endif

    uart_host_rx #(
        .SYS_CLK_FREQ(16),
        .BAUD_RATE   (1),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Error pulses are counted once per high cycle
    always @(posedge clk) begin
        if (frame_err)  fe_cnt++;
        if (parity_err) pe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives start, data (and parity) bits; returns at the start of the stop bit
    task automatic send_head(input logic [7:0] d);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef UART_HOST_RX_PARITY_EN
        rx = (^d) ^ par_inv;
        repeat (CPB) @(negedge clk);
`endif
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_head(d);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte, with exact start-edge-to-empty latency
        send_head(8'hA5);
        rx = 1'b1;
        repeat (11) @(negedge clk);
        chk("t1_empty_before", 32'(empty), 32'd1);
        @(negedge clk);
        chk("t1_empty_after", 32'(empty), 32'd0);
        repeat (4) @(negedge clk);
        chk("t1_rd_data", 32'(rd_data), 32'hA5);
        pop();
        chk("t1_empty_pop", 32'(empty), 32'd1);
        pop();
        chk("t1_pop_when_empty", 32'(empty), 32'd1);
        chk("t1_full", 32'(full), 32'd0);
        chk("t1_frame_err", 32'(fe_cnt), 32'd0);
        chk("t1_overflow", 32'(overflow), 32'd0);

        // Short glitch is rejected
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("t2_empty", 32'(empty), 32'd1);
        chk("t2_frame_err", 32'(fe_cnt), 32'd0);

        // Framing error, break, then a good frame
        send_head(8'h3C);
        rx = 1'b0;
        repeat (CPB + 40) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("t3_frame_err_once", 32'(fe_cnt), 32'd1);
        chk("t3_empty_after_ferr", 32'(empty), 32'd1);
        send_frame(8'h55);
        repeat (2) @(negedge clk);
        chk("t3_empty", 32'(empty), 32'd0);
        chk("t3_rd_data", 32'(rd_data), 32'h55);
        pop();
        chk("t3_only_one", 32'(empty), 32'd1);
        chk("t3_frame_err_total", 32'(fe_cnt), 32'd1);

        // Fill, overflow, drain
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i));
            if (i == 14) chk("t4_not_full_15", 32'(full), 32'd0);
            if (i == 15) begin
                chk("t4_full_16", 32'(full), 32'd1);
                chk("t4_no_overflow_16", 32'(overflow), 32'd0);
            end
        end
        chk("t4_overflow_17", 32'(overflow), 32'd1);
        chk("t4_full_17", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4_read_%0d", i), 32'(rd_data), 32'(i));
            pop();
            if (i == 0) chk("t4_not_full_after_pop", 32'(full), 32'd0);
        end
        chk("t4_empty_drained", 32'(empty), 32'd1);
        chk("t4_overflow_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a frame of 0xFF
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rd_data", 32'(rd_data), 32'h00);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_full", 32'(full), 32'd0);
        chk("t5_overflow", 32'(overflow), 32'd0);
        chk("t5_frame_err", 32'(frame_err), 32'd0);
        chk("t5_parity_err", 32'(parity_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("t5_no_partial", 32'(empty), 32'd1);
        send_frame(8'h81);
        repeat (2) @(negedge clk);
        chk("t5_empty_after", 32'(empty), 32'd0);
        chk("t5_rd_data_after", 32'(rd_data), 32'h81);
        pop();
        chk("t5_single_byte", 32'(empty), 32'd1);

`ifdef UART_HOST_RX_PARITY_EN
        // Bad parity drops the byte; good parity pushes it
        par_inv = 1'b1;
        send_frame(8'h01);
        repeat (2) @(negedge clk);
        chk("t6_parity_err", 32'(pe_cnt), 32'd1);
        chk("t6_no_push", 32'(empty), 32'd1);
        par_inv = 1'b0;
        send_frame(8'h01);
        repeat (2) @(negedge clk);
        chk("t6_parity_err_total", 32'(pe_cnt), 32'd1);
        chk("t6_empty", 32'(empty), 32'd0);
        chk("t6_rd_data", 32'(rd_data), 32'h01);
        pop();
`else
        chk("t6_parity_never", 32'(pe_cnt), 32'd0);
`endif
        chk("end_frame_err_total", 32'(fe_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_host_rx.md
Name: uart_host_rx

Overview:
- Synthesizable UART receiver for the host end of the CPU's serial link.
- Deserialises the riscv_top Tx line into bytes and buffers them in a FIFO for a consumer: host-side logic, on-board debug, or a loopback bench.
- Mirrors the CPU-side transmitter: 8N1 framing, LSB first, same baud configuration.

Parameters:
SYS_CLK_FREQ, 100000000, clk frequency in Hz
BAUD_RATE, 115200, line rate; CLKS_PER_BIT = SYS_CLK_FREQ / BAUD_RATE (integer, truncating, must be >= 4)
FIFO_DEPTH, 16, receive FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous active-high reset
rx  input  1  serial line, idle high, asynchronous to clk
rd_en  input  1  pop request; ignored when empty
rd_data  output  8  FIFO head (first-word-fall-through); 0 after reset
empty  output  1  FIFO empty; 1 after reset
full  output  1  FIFO holds FIFO_DEPTH bytes; 0 after reset
overflow  output  1  sticky: byte dropped because FIFO full; cleared only by rst; 0 after reset
frame_err  output  1  one-cycle pulse: stop bit sampled 0; 0 after reset
parity_err  output  1  one-cycle pulse: parity mismatch (only with macro); tied 0 otherwise

Behaviour:
- rx passes through a 2-flop synchroniser reset to 1. "rx_s" below is the synchronised value.
- Reset is asynchronous, from any state. FSM goes to IDLE. Bit counter, sample counter and FIFO pointers clear. Any partial frame is discarded.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
  - IDLE: a 1->0 transition on rx_s moves to START and clears the sample counter.
  - START: at count CLKS_PER_BIT/2 - 1, sample rx_s.
    - 0: go to DATA and restart the counter.
    - 1: glitch; return to IDLE, nothing logged.
  - DATA: sample every CLKS_PER_BIT clocks, so each sample lands mid-bit. Shift in LSB first. After bit 7, go to PARITY (macro) or STOP.
  - STOP: sample after CLKS_PER_BIT.
    - 1: push the byte and go to IDLE.
    - 0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait until rx_s = 1, then go to IDLE. A held-low line never produces bytes.
- Push timing: the byte is written on the cycle after the stop sample. empty drops on the following edge.
- Total latency, rx start edge to empty low: 2 (sync) + CLKS_PER_BIT/2 + 9×CLKS_PER_BIT (+CLKS_PER_BIT with parity) + 2 cycles.
- FIFO: FIFO_DEPTH entries, pointers of log2(FIFO_DEPTH)+1 bits, wrap modulo depth.
  - rd_data always shows the head entry; it is undefined-but-stable when empty. Pop takes effect on the edge where rd_en = 1 and empty = 0.
  - Push when full with no simultaneous pop: byte dropped, overflow set.
  - Simultaneous push and pop when full: both succeed, occupancy unchanged, overflow not set.
  - Simultaneous push and pop when empty: push only; the pop is ignored.
- frame_err and parity_err never coincide with a push. The error pulses are independent of FIFO state.

Optional Feature:
- Macro UART_HOST_RX_PARITY_EN.
- Defined:
  - The PARITY state follows DATA and samples one bit.
  - Even parity is required: XOR of the 8 data bits and the parity bit equals 0.
  - On mismatch, parity_err pulses for one cycle. STOP is still checked for timing, but the byte is not pushed.
  - Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state; parity_err is constant 0; frame is 8N1.

Test Plan:
All cases use SYS_CLK_FREQ=16, BAUD_RATE=1 (CLKS_PER_BIT=16) and FIFO_DEPTH=16 unless noted.
1. Send frame 0xA5 with 16-clk bits -> empty falls; rd_data=0xA5; one rd_en cycle -> empty=1. frame_err, overflow stay 0.
2. Pulse rx low for 4 clks, then high -> FSM back in IDLE; empty stays 1; no error pulses.
3. Send 0x3C with stop bit 0, hold rx low 40 clks, then high, then send 0x55 -> frame_err pulses exactly once; only 0x55 enters the FIFO.
4. Send 0x00..0x10 (17 frames) with no reads -> full=1 after the 16th; overflow=1 after the 17th; reads return 0x00..0x0F, then empty=1.
5. Assert rst during data bit 3 of 0xFF, release, send 0x81 -> all outputs at reset values while rst is high; afterwards exactly one byte, 0x81, received.
6. With UART_HOST_RX_PARITY_EN: 0x01 with parity bit 0 -> parity_err pulse, no push. 0x01 with parity bit 1 -> 0x01 pushed. Without the macro, the 8N1 case 1 still passes.
